// File: rtl/iopmp_scan_pkg.sv
// Shared types and constants for the IOPMP match scanner.
//   scan_state_e : scanner FSM state (IDLE, SCAN, NONE), 2-bit encoding
//   MinEntries   : smallest legal match-vector width
//   idx_width()  : index width needed to address n entries (at least 1)
package iopmp_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        NONE = 2'd2
    } scan_state_e;

    localparam int MinEntries = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter.
//   in_i    : input vector
//   cnt_o   : MODE=0 -> index of lowest set bit (trailing zeros)
//             MODE=1 -> number of leading zeros
//   empty_o : input vector is all zeros (cnt_o is 0 then)
module lzc #(
    parameter int WIDTH     = 2,
    parameter bit MODE      = 1'b0,
    parameter int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o   = '0;
        empty_o = (in_i == '0);
        if (MODE == 1'b0) begin
            // Walk from the top so the lowest set bit wins.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(i);
            end
        end else begin
            // Walk from the bottom so the highest set bit wins.
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/iopmp_match_scanner.sv
// Serialises an IOPMP entry-match vector into a stream of matched indices,
// lowest index first, one beat per cycle.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : abort current scan, drop residual state
//   vec_valid_i/vec_ready_o/vec_i : match vector input handshake
//   idx_valid_o/idx_ready_i       : index beat output handshake
//   idx_o       : index of lowest remaining set bit
//   idx_last_o  : final beat for the current vector
//   idx_none_o  : vector had no set bits (single beat, idx_o=0)
//   beat_cnt_o  : beats already accepted for the current vector
module iopmp_match_scanner
    import iopmp_scan_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_WIDTH   = idx_width(NUM_ENTRIES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   vec_valid_i,
    output logic                   vec_ready_o,
    input  logic [NUM_ENTRIES-1:0] vec_i,
    output logic                   idx_valid_o,
    input  logic                   idx_ready_i,
    output logic [IDX_WIDTH-1:0]   idx_o,
    output logic                   idx_last_o,
    output logic                   idx_none_o,
    output logic [IDX_WIDTH:0]     beat_cnt_o
);

    localparam int CntW = IDX_WIDTH + 1;

    if (NUM_ENTRIES < MinEntries) begin : g_bad_num_entries
        $error("iopmp_match_scanner: NUM_ENTRIES must be >= 2");
    end

    scan_state_e            state;
    logic [NUM_ENTRIES-1:0] residual;
    logic [CntW-1:0]        beat_cnt;

    logic [IDX_WIDTH-1:0]   lzc_cnt;
    logic                   lzc_empty;
    logic [NUM_ENTRIES-1:0] residual_drop_low;
    logic                   scan_last;

    lzc #(
        .WIDTH     (NUM_ENTRIES),
        .MODE      (1'b0),
        .CNT_WIDTH (IDX_WIDTH)
    ) u_lzc (
        .in_i    (residual),
        .cnt_o   (lzc_cnt),
        .empty_o (lzc_empty)
    );

    // x & (x-1) clears exactly the lowest set bit, which is the bit the
    // lzc just reported; zero result means this is the final beat.
    assign residual_drop_low = residual & (residual - NUM_ENTRIES'(1));
    assign scan_last         = (residual_drop_low == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state    <= IDLE;
            residual <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (vec_valid_i) begin
                        residual <= vec_i;
                        beat_cnt <= '0;
                        state    <= (vec_i != '0) ? SCAN : NONE;
                    end
                end
                SCAN: begin
                    if (idx_ready_i) begin
                        residual <= residual_drop_low;
                        beat_cnt <= beat_cnt + CntW'(1);
                        if (scan_last) state <= IDLE;
                    end
                end
                NONE: begin
                    if (idx_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only: no input-to-output paths.
    always_comb begin
        vec_ready_o = 1'b0;
        idx_valid_o = 1'b0;
        idx_o       = '0;
        idx_last_o  = 1'b0;
        idx_none_o  = 1'b0;
        case (state)
            IDLE: vec_ready_o = 1'b1;
            SCAN: begin
                idx_valid_o = 1'b1;
                idx_o       = lzc_cnt;
                idx_last_o  = scan_last;
            end
            NONE: begin
                idx_valid_o = 1'b1;
                idx_last_o  = 1'b1;
                idx_none_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign beat_cnt_o = beat_cnt;

`ifndef SYNTHESIS
    // residual is non-zero whenever SCAN is entered or held.
    a_scan_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == SCAN) |-> !lzc_empty);
`endif

endmodule
